// File: rtl/sw_input_reader_pkg.sv
// Shared event-field positions and timing defaults for the switch input reader.
// Event word layout: channel index above the level bit; level always in the LSB.
package sw_input_reader_pkg;

    localparam int EVT_LVL_BIT    = 0;
    localparam int EVT_IDX_LSB    = 1;
    localparam int DEBOUNCE_16MHZ = 16000;

endpackage

// File: rtl/sw_event_fifo.sv
// First-word fall-through event queue; push lands at the head one clock later when empty.
// A push while full is only taken alongside a pop; the head is held steady until popped.
module sw_event_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/sw_input_reader.sv
// Switch conditioning: sync, debounce, edge pulses, change events (SW_INPUT_TOGGLE_EN adds toggle latches).
// Pin->SW_STATE 2+DEBOUNCE_CYCLES clocks, event one clock later; stalled events wait in per-channel pending bits.
module sw_input_reader
    import sw_input_reader_pkg::*;
#(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_16MHZ,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [N_SW-1:0]       SW,
    output logic [N_SW-1:0]       SW_STATE,
    output logic [N_SW-1:0]       SW_RISE,
    output logic [N_SW-1:0]       SW_FALL,
    output logic [N_SW-1:0]       SW_TOGGLE,
    output logic                  EVT_VALID,
    input  logic                  EVT_READY,
    output logic [$clog2(N_SW):0] EVT_DATA,
    output logic                  EVT_OVERFLOW,
    input  logic                  OVF_CLR
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int               DATA_W  = $clog2(N_SW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_SW-1:0]   state_q, state_d;
    logic [N_SW-1:0]   rise_q, rise_d, fall_q, fall_d;
    logic [N_SW-1:0]   pend_q, pend_d;
    logic [N_SW-1:0]   flip, sel_oh, push_mask;
    logic [CNT_W-1:0]  cnt_q [N_SW];
    logic [CNT_W-1:0]  cnt_d [N_SW];
    logic              ovf_q, ovf_d, ovf_set;
    logic              sel_vld, sel_lvl;
    logic [DATA_W-1:0] sel_idx, push_dat, head_dat;
    logic              fifo_full, fifo_empty, fifo_pop, fifo_push;

    // Counter tracks consecutive disagreement; the final disagreeing cycle flips the level.
    always_comb begin
        sync1_d = SW;
        sync2_d = sync1_q;
        flip    = '0;
        for (int i = 0; i < N_SW; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    flip[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        state_d = state_q ^ flip;
        rise_d  = flip & ~state_q;
        fall_d  = flip & state_q;
    end

    // Lowest pending channel wins; a change landing on a channel as it pushes re-arms it cleanly.
    always_comb begin
        sel_vld = 1'b0;
        sel_lvl = 1'b0;
        sel_idx = '0;
        sel_oh  = '0;
        for (int i = N_SW - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_vld    = 1'b1;
                sel_lvl    = state_q[i];
                sel_idx    = DATA_W'(i);
                sel_oh     = '0;
                sel_oh[i]  = 1'b1;
            end
        end
        fifo_pop  = !fifo_empty && EVT_READY;
        fifo_push = sel_vld && (!fifo_full || fifo_pop);
        push_dat  = (sel_idx << EVT_IDX_LSB) | (DATA_W'(sel_lvl) << EVT_LVL_BIT);
        push_mask = fifo_push ? sel_oh : '0;
        ovf_set   = |(flip & pend_q & ~push_mask);
        pend_d    = flip | (pend_q & ~push_mask);
        ovf_d     = ovf_set || (ovf_q && !OVF_CLR);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef SW_INPUT_TOGGLE_EN
    logic [N_SW-1:0] tog_q, tog_d;

    always_comb begin
        tog_d = tog_q ^ rise_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tog_q <= '0;
        end else begin
            tog_q <= tog_d;
        end
    end

    assign SW_TOGGLE = tog_q;
`else
    assign SW_TOGGLE = '0;
`endif

    sw_event_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk      (CLK),
        .rst_n    (RST_N),
        .push     (fifo_push),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign SW_STATE     = state_q;
    assign SW_RISE      = rise_q;
    assign SW_FALL      = fall_q;
    assign EVT_VALID    = !fifo_empty;
    assign EVT_DATA     = head_dat;
    assign EVT_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_sw_input_reader.sv
// Bench for sw_input_reader: directed table, hand-written corner sequences, random traffic vs a reference model.
// SW_INPUT_TOGGLE_EN selects the toggle expectations.
module tb_sw_input_reader;

    localparam int N  = 4;
    localparam int DC = 8;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       evt_ready;
    logic       ovf_clr;
    logic [3:0] sw_state, sw_rise, sw_fall, sw_toggle;
    logic       evt_valid, evt_overflow;
    logic [2:0] evt_data;

    int errors = 0;
    int checks = 0;

    sw_input_reader #(
        .N_SW            (N),
        .DEBOUNCE_CYCLES (DC),
        .FIFO_DEPTH      (FD)
    ) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .SW           (sw),
        .SW_STATE     (sw_state),
        .SW_RISE      (sw_rise),
        .SW_FALL      (sw_fall),
        .SW_TOGGLE    (sw_toggle),
        .EVT_VALID    (evt_valid),
        .EVT_READY    (evt_ready),
        .EVT_DATA     (evt_data),
        .EVT_OVERFLOW (evt_overflow),
        .OVF_CLR      (ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: a level changes once the synchronised pin has disagreed with it
    // for DC straight samples; change events go through a plain queue.
    logic [3:0] m_state, m_rise, m_fall, m_tog, m_pend;
    logic       m_ovf;
    logic [2:0] m_q[$];
    logic [3:0] m_hist [0:DC];

    task automatic model_reset();
        m_state = '0; m_rise = '0; m_fall = '0; m_tog = '0; m_pend = '0; m_ovf = 1'b0;
        m_q.delete();
        for (int k = 0; k <= DC; k++) m_hist[k] = '0;
    endtask

    task automatic model_edge();
        logic [3:0] chg;
        int         sel;
        bit         popped, pushed, ovf_set, differs;
        for (int i = 0; i < N; i++) begin
            differs = 1'b1;
            for (int k = 0; k < DC; k++)
                if (m_hist[1+k][i] == m_state[i]) differs = 1'b0;
            chg[i] = differs;
        end
        popped = (m_q.size() > 0) && evt_ready;
        sel = -1;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && sel < 0) sel = i;
        pushed = (sel >= 0) && ((m_q.size() < FD) || popped);
        if (popped) void'(m_q.pop_front());
        if (pushed) m_q.push_back({sel[1:0], m_state[sel]});
        ovf_set = 1'b0;
        for (int i = 0; i < N; i++)
            if (chg[i] && m_pend[i] && !(pushed && sel == i)) ovf_set = 1'b1;
        m_ovf = ovf_set || (m_ovf && !ovf_clr);
        for (int i = 0; i < N; i++) begin
            if (pushed && sel == i) m_pend[i] = 1'b0;
            if (chg[i]) m_pend[i] = 1'b1;
        end
        m_rise = chg & ~m_state;
        m_fall = chg & m_state;
`ifdef SW_INPUT_TOGGLE_EN
        m_tog = m_tog ^ m_rise;
`endif
        m_state = m_state ^ chg;
        for (int k = DC; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = sw;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [2:0] ed;
        ed = '0;
        if (m_q.size() > 0) ed = m_q[0];
        chk("state", sw_state, m_state);
        chk("rise", sw_rise, m_rise);
        chk("fall", sw_fall, m_fall);
        chk("toggle", sw_toggle, m_tog);
        chk("evt_valid", evt_valid, m_q.size() > 0);
        chk("evt_data", evt_data, ed);
        chk("overflow", evt_overflow, m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        sw = v;
        repeat (n) step();
    endtask

    task automatic drain5(input string nm, input logic [14:0] seq);
        logic [2:0] e;
        evt_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            e = seq[14-3*j -: 3];
            chk($sformatf("%s_vld%0d", nm, j), evt_valid, 1);
            chk($sformatf("%s_dat%0d", nm, j), evt_data, e);
            step();
        end
        chk({nm, "_empty"}, evt_valid, 0);
    endtask

    typedef struct {
        logic [3:0] sw;
        int         hold;
        logic [3:0] st;
        logic [3:0] rise;
        logic       vld;
        logic [2:0] dat;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{4'b0001,  9, 4'b0000, 4'b0000, 1'b0, 3'b000};
        vecs[1]  = '{4'b0001,  1, 4'b0001, 4'b0001, 1'b0, 3'b000};
        vecs[2]  = '{4'b0001,  1, 4'b0001, 4'b0000, 1'b1, 3'b001};
        vecs[3]  = '{4'b0001,  1, 4'b0001, 4'b0000, 1'b0, 3'b000};
        vecs[4]  = '{4'b0011,  7, 4'b0001, 4'b0000, 1'b0, 3'b000};
        vecs[5]  = '{4'b0001, 12, 4'b0001, 4'b0000, 1'b0, 3'b000};
        vecs[6]  = '{4'b0000, 10, 4'b0000, 4'b0000, 1'b0, 3'b000};
        vecs[7]  = '{4'b0000,  1, 4'b0000, 4'b0000, 1'b1, 3'b000};
        vecs[8]  = '{4'b0000,  1, 4'b0000, 4'b0000, 1'b0, 3'b000};
        vecs[9]  = '{4'b1111, 10, 4'b1111, 4'b1111, 1'b0, 3'b000};
        vecs[10] = '{4'b1111,  1, 4'b1111, 4'b0000, 1'b1, 3'b001};
        vecs[11] = '{4'b1111,  1, 4'b1111, 4'b0000, 1'b1, 3'b011};
        vecs[12] = '{4'b1111,  1, 4'b1111, 4'b0000, 1'b1, 3'b101};
        vecs[13] = '{4'b1111,  1, 4'b1111, 4'b0000, 1'b1, 3'b111};
        vecs[14] = '{4'b1111,  1, 4'b1111, 4'b0000, 1'b0, 3'b000};

        rst_n = 1'b0; sw = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_state", sw_state, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_data", evt_data, 0);
        chk("rst_ovf", evt_overflow, 0);
        chk("rst_toggle", sw_toggle, 0);

        // Single press, short glitch, simultaneous changes draining one per cycle.
        evt_ready = 1'b1;
        for (int v = 0; v < 15; v++) begin
            hold(vecs[v].sw, vecs[v].hold);
            chk($sformatf("vec%0d_state", v), sw_state, vecs[v].st);
            chk($sformatf("vec%0d_rise", v), sw_rise, vecs[v].rise);
            chk($sformatf("vec%0d_valid", v), evt_valid, vecs[v].vld);
            chk($sformatf("vec%0d_data", v), evt_data, vecs[v].dat);
        end

        // Backpressure: four queued, fifth waits pending without overflow.
        evt_ready = 1'b0;
        hold(4'b1110, 12);
        hold(4'b1100, 12);
        hold(4'b1000, 12);
        hold(4'b0000, 12);
        hold(4'b0001, 12);
        chk("bp_state", sw_state, 4'b0001);
        chk("bp_ovf", evt_overflow, 0);
        drain5("bp", {3'b000, 3'b010, 3'b100, 3'b110, 3'b001});

        // Two changes on a stalled pending channel coalesce and flag overflow.
        evt_ready = 1'b0;
        hold(4'b0011, 12);
        hold(4'b0111, 12);
        hold(4'b1111, 12);
        hold(4'b1110, 12);
        hold(4'b1100, 12);
        chk("ovf_before", evt_overflow, 0);
        hold(4'b1110, 12);
        chk("ovf_set", evt_overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", evt_overflow, 0);
        drain5("coal", {3'b011, 3'b101, 3'b111, 3'b000, 3'b011});

        // Asynchronous reset mid-debounce with two events queued.
        evt_ready = 1'b0;
        hold(4'b1111, 12);
        hold(4'b0111, 12);
        hold(4'b0101, 7);
        chk("pre_rst_valid", evt_valid, 1);
        chk("pre_rst_state", sw_state, 4'b0111);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_state", sw_state, 0);
        chk("arst_valid", evt_valid, 0);
        chk("arst_data", evt_data, 0);
        chk("arst_ovf", evt_overflow, 0);
        chk("arst_edges", {sw_rise, sw_fall}, 0);
        repeat (2) step();
        rst_n = 1'b1;
        chk("post_rst_valid", evt_valid, 0);
        repeat (9) step();
        chk("post_rst_state9", sw_state, 0);
        chk("post_rst_valid9", evt_valid, 0);
        step();
        chk("post_rst_state10", sw_state, 4'b0101);
        step();
        chk("post_rst_evt", evt_data, 3'b001);

        // Toggle latch across three press/release cycles.
        sw = '0;
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
        evt_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            logic exp_t;
`ifdef SW_INPUT_TOGGLE_EN
            exp_t = (p % 2 == 0);
`else
            exp_t = 1'b0;
`endif
            hold(4'b0100, 12);
            chk($sformatf("toggle_press%0d", p), sw_toggle[2], exp_t);
            hold(4'b0000, 12);
        end

        // Random pin activity, bursty readiness, occasional clears and one mid-run reset.
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 11) == 0) sw[b] = ~sw[b];
            evt_ready = (c % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            ovf_clr = ($urandom_range(0, 39) == 0);
            if (c == 2500) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_all();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
